// File: rtl/psg_sched_pkg.sv
// Shared types and constants for the PSG mix scheduler.
//   sched_state_t : frame sequencer states
//   VOL_TABLE     : 4-bit volume code to unsigned 16-bit gain; roughly 3 dB
//                   per step, code 0 is silent and code 15 is 65535
//   sat_s16       : clamp a signed 24-bit value to the signed 16-bit range
package psg_sched_pkg;

  localparam int SAMPLE_W = 16;
  localparam int VOL_W    = 4;
  localparam int GAIN_W   = 16;
  localparam int PROD_W   = SAMPLE_W + GAIN_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_MUL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_OUT  = 3'd4
  } sched_state_t;

  // round(65535 * 10^(-(15-v)*3/20)) for v >= 1
  localparam logic [GAIN_W-1:0] VOL_TABLE [16] = '{
    16'd0,     16'd521,   16'd735,   16'd1039,
    16'd1467,  16'd2072,  16'd2927,  16'd4135,
    16'd5841,  16'd8250,  16'd11654, 16'd16462,
    16'd23253, 16'd32845, 16'd46395, 16'd65535
  };

  function automatic logic signed [SAMPLE_W-1:0] sat_s16(input logic signed [23:0] v);
    if (v > 24'sd32767)
      return 16'sh7FFF;
    else if (v < -24'sd32768)
      return 16'sh8000;
    else
      return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/psg_vol_mul.sv
// Volume multiplier shared by all channels of the PSG mix scheduler.
// Looks up the gain for the 4-bit volume code and registers the signed
// operand times the unsigned gain; one cycle of latency, updated only when
// mul_en is high.
// Ports:
//   clk_27MHz, reset_n : clock, async active-low reset
//   mul_en             : load the product register this cycle
//   operand            : signed 16-bit channel value
//   vol                : 4-bit volume code
//   product            : registered signed 33-bit product
module psg_vol_mul
  import psg_sched_pkg::*;
(
  input  logic                     clk_27MHz,
  input  logic                     reset_n,
  input  logic                     mul_en,
  input  logic signed [SAMPLE_W-1:0] operand,
  input  logic [VOL_W-1:0]         vol,
  output logic signed [PROD_W-1:0] product
);

  logic [GAIN_W-1:0] gain;

  assign gain = VOL_TABLE[vol];

  // Zero-extend the gain so the multiply stays signed.
  always_ff @(posedge clk_27MHz or negedge reset_n) begin
    if (!reset_n)
      product <= '0;
    else if (mul_en)
      product <= operand * $signed({1'b0, gain});
  end

endmodule

// File: rtl/psg_mix_scheduler.sv
// Per-sample sequencer for the 3-operator PSG audio path.
// A rising edge of clk_48kHz starts a frame: every channel generator is
// asked for one value over a req/ack handshake, each value is scaled by its
// volume through the shared psg_vol_mul, and the scaled values are summed,
// saturated and presented on sample with a one-cycle sample_valid pulse.
// Optional feature: define DC_BLOCK_EN to add a one-pole DC blocker after
// saturation (one extra cycle of latency; parameter DC_K sets the pole).
// Ports:
//   clk_27MHz, reset_n : clock, async active-low reset
//   clk_48kHz          : sample-rate square wave, same clock domain
//   enable             : allow new frames to start
//   ch_vol             : 4-bit volume per channel, ch i at [4i+3:4i]
//   ch_req / ch_ack    : one-hot request, per-channel ack (data valid with ack)
//   ch_data            : signed 16-bit value per channel, ch i at [16i+15:16i]
//   sample, sample_valid : mixed output and its update strobe
//   overrun, timeout_err : sticky error flags, cleared by err_clr
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a strobe edge with enable high
// WAIT    | ch_req[ch_idx] high, waiting for ack or the wait timer
// MUL     | shared multiplier scales the captured operand
// ACC     | add the scaled term, move to the next channel or OUT
// OUT     | saturate the accumulator and update sample
module psg_mix_scheduler
  import psg_sched_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int TIMEOUT = 64,
  parameter int ACC_W   = 18
`ifdef DC_BLOCK_EN
  ,
  parameter int DC_K    = 10
`endif
)
(
  input  logic                   clk_27MHz,
  input  logic                   reset_n,
  input  logic                   clk_48kHz,
  input  logic                   enable,
  input  logic [4*NUM_CH-1:0]    ch_vol,
  output logic [NUM_CH-1:0]      ch_req,
  input  logic [NUM_CH-1:0]      ch_ack,
  input  logic [16*NUM_CH-1:0]   ch_data,
  output logic [15:0]            sample,
  output logic                   sample_valid,
  output logic                   overrun,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  sched_state_t                state;
  logic [CH_W-1:0]             ch_idx;
  logic [TO_W-1:0]             wait_cnt;
  logic signed [SAMPLE_W-1:0]  operand;
  logic signed [ACC_W-1:0]     acc;
  logic signed [PROD_W-1:0]    product;
  logic signed [PROD_W-GAIN_W-1:0] term;
  logic signed [SAMPLE_W-1:0]  acc_sat;
  logic                        clk_48k_q;
  logic                        clk_48k_qq;
  logic                        edge_det;
  logic                        cur_ack;
  logic                        timeout_set;
  logic                        overrun_set;

  always_ff @(posedge clk_27MHz or negedge reset_n) begin
    if (!reset_n) begin
      clk_48k_q  <= 1'b0;
      clk_48k_qq <= 1'b0;
    end else begin
      clk_48k_q  <= clk_48kHz;
      clk_48k_qq <= clk_48k_q;
    end
  end

  assign edge_det    = clk_48k_q & ~clk_48k_qq;
  assign cur_ack     = ch_ack[ch_idx];
  assign timeout_set = (state == ST_WAIT) && !cur_ack && (wait_cnt == '0);
  assign overrun_set = edge_det && (state != ST_IDLE);

  // Floor of product / 2^16, i.e. the arithmetic shift by the gain width.
  assign term    = $signed(product[PROD_W-1:GAIN_W]);
  assign acc_sat = sat_s16(24'(acc));

  always_comb begin
    ch_req = '0;
    if (state == ST_WAIT)
      ch_req[ch_idx] = 1'b1;
  end

  always_ff @(posedge clk_27MHz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ch_idx   <= '0;
      wait_cnt <= '0;
      operand  <= '0;
      acc      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (edge_det && enable) begin
            state    <= ST_WAIT;
            ch_idx   <= '0;
            wait_cnt <= TO_LOAD;
            acc      <= '0;
          end
        end
        ST_WAIT: begin
          if (cur_ack) begin
            operand <= ch_data[{ch_idx, 4'b0} +: 16];
            state   <= ST_MUL;
          end else if (wait_cnt == '0) begin
            operand <= '0;
            state   <= ST_MUL;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_MUL: state <= ST_ACC;
        ST_ACC: begin
          acc <= acc + ACC_W'(term);
          if (ch_idx == LAST_CH) begin
            state <= ST_OUT;
          end else begin
            ch_idx   <= ch_idx + 1'b1;
            wait_cnt <= TO_LOAD;
            state    <= ST_WAIT;
          end
        end
        ST_OUT:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  psg_vol_mul u_vol_mul (
    .clk_27MHz (clk_27MHz),
    .reset_n   (reset_n),
    .mul_en    (state == ST_MUL),
    .operand   (operand),
    .vol       (ch_vol[{ch_idx, 2'b0} +: 4]),
    .product   (product)
  );

  // Set has priority over err_clr in the same cycle.
  always_ff @(posedge clk_27MHz or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (overrun_set)
        overrun <= 1'b1;
      else if (err_clr)
        overrun <= 1'b0;
      if (timeout_set)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

`ifdef DC_BLOCK_EN
  logic signed [SAMPLE_W-1:0] x_cur;
  logic signed [SAMPLE_W-1:0] x_prev;
  logic signed [19:0]         y_prev;
  logic signed [21:0]         y_full;
  logic signed [19:0]         y_next;
  logic                       flt_go;

  // y = x - x_prev + y_prev - y_prev/2^DC_K, kept in a clamped 20-bit state
  assign y_full = 22'(x_cur) - 22'(x_prev) + 22'(y_prev) - 22'(y_prev >>> DC_K);

  always_comb begin
    y_next = y_full[19:0];
    if (y_full > 22'sd524287)
      y_next = 20'sh7FFFF;
    else if (y_full < -22'sd524288)
      y_next = 20'sh80000;
  end

  always_ff @(posedge clk_27MHz or negedge reset_n) begin
    if (!reset_n) begin
      x_cur        <= '0;
      x_prev       <= '0;
      y_prev       <= '0;
      flt_go       <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      flt_go       <= (state == ST_OUT);
      sample_valid <= flt_go;
      if (state == ST_OUT)
        x_cur <= acc_sat;
      if (flt_go) begin
        x_prev <= x_cur;
        y_prev <= y_next;
        sample <= sat_s16(24'(y_next));
      end
    end
  end
`else
  always_ff @(posedge clk_27MHz or negedge reset_n) begin
    if (!reset_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= (state == ST_OUT);
      if (state == ST_OUT)
        sample <= acc_sat;
    end
  end
`endif

endmodule

// File: tb/tb_psg_mix_scheduler.sv
`timescale 1ns/1ps
module tb_psg_mix_scheduler;

  logic               clk_27MHz = 1'b0;
  logic               reset_n   = 1'b0;
  logic               clk_48kHz = 1'b0;
  logic               enable    = 1'b1;
  logic [11:0]        ch_vol    = '0;
  logic [2:0]         ch_req;
  logic [2:0]         ch_ack    = '0;
  logic [47:0]        ch_data   = '0;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               overrun;
  logic               timeout_err;
  logic               err_clr   = 1'b0;

  typedef struct {
    int smp;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   n_valid = 0;
  int   req_cnt [3] = '{0, 0, 0};
  logic [2:0] req_prev = '0;

  psg_mix_scheduler dut (
    .clk_27MHz    (clk_27MHz),
    .reset_n      (reset_n),
    .clk_48kHz    (clk_48kHz),
    .enable       (enable),
    .ch_vol       (ch_vol),
    .ch_req       (ch_req),
    .ch_ack       (ch_ack),
    .ch_data      (ch_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  always #5 clk_27MHz = ~clk_27MHz;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_term(input int d, input int v);
    longint g;
    case (v)
      15:      g = 65535;
      12:      g = 23253;
      default: g = 0;
    endcase
    return int'((longint'(d) * g) >>> 16);
  endfunction

  function automatic int model_sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(posedge clk_27MHz) cyc++;

  always @(negedge clk_27MHz) begin
    for (int i = 0; i < 3; i++)
      if (ch_req[i] && !req_prev[i]) req_cnt[i]++;
    req_prev = ch_req;
    if (sample_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        check_val("spurious_valid", 32'(sample_valid), 0);
      end else begin
        sb_e = sb_q.pop_front();
        check_val("sample", sample, sb_e.smp);
        check_val("latency", cyc - t0, sb_e.lat);
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk_27MHz);
      n++;
    end
    check_val("frame_done", sb_q.size(), 0);
  endtask

  task automatic run_frame(input int d0, input int d1, input int d2,
                           input int v0, input int v1, input int v2,
                           input logic [2:0] ack, input bit drop_en);
    int sum = 0;
    int lat = 12;
    int d [3];
    int v [3];
    d = '{d0, d1, d2};
    v = '{v0, v1, v2};
    for (int i = 0; i < 3; i++) begin
      if (ack[i]) sum += model_term(d[i], v[i]);
      else        lat += 63;
    end
    ch_data = {16'(d2), 16'(d1), 16'(d0)};
    ch_vol  = {4'(v2), 4'(v1), 4'(v0)};
    ch_ack  = ack;
    sb_q.push_back('{model_sat(sum), lat});
    @(negedge clk_27MHz);
    clk_48kHz = 1'b1;
    t0 = cyc;
    if (drop_en) begin
      repeat (3) @(negedge clk_27MHz);
      enable = 1'b0;
    end
    wait_done(300);
    enable    = 1'b1;
    clk_48kHz = 1'b0;
    repeat (3) @(negedge clk_27MHz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int nv;
    int rc [3];

    repeat (3) @(negedge clk_27MHz);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_27MHz);
    check_val("rst_sample", sample, 0);
    check_val("rst_valid", 32'(sample_valid), 0);
    check_val("rst_req", 32'(ch_req), 0);
    check_val("rst_overrun", 32'(overrun), 0);
    check_val("rst_timeout", 32'(timeout_err), 0);

    // full-scale positive saturates, full-scale negative lands on -32768
    run_frame(32767, 32767, 32767, 15, 15, 15, 3'b111, 1'b0);
    run_frame(-32768, -32768, -32768, 15, 15, 15, 3'b111, 1'b0);
    // floor rounding; enable falls mid-frame and the frame still completes
    run_frame(1000, -1000, 0, 15, 15, 15, 3'b111, 1'b1);

    // mixed volumes; the silent channel must still get its handshake
    rc = req_cnt;
    run_frame(20000, 5000, -300, 12, 0, 15, 3'b111, 1'b0);
    for (int i = 0; i < 3; i++)
      check_val($sformatf("req_count_ch%0d", i), req_cnt[i] - rc[i], 1);
    check_val("no_timeout_yet", 32'(timeout_err), 0);

    // ch1 never acks; ch2 ack while waiting on ch1 must be ignored
    run_frame(100, 12345, 100, 15, 15, 15, 3'b101, 1'b0);
    check_val("timeout_set", 32'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge clk_27MHz);
    err_clr = 1'b0;
    check_val("timeout_clr", 32'(timeout_err), 0);

    // enable low in IDLE: edge ignored, no overrun, sample holds
    nv = n_valid;
    enable = 1'b0;
    clk_48kHz = 1'b1;
    repeat (20) @(negedge clk_27MHz);
    clk_48kHz = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk_27MHz);
    check_val("disabled_no_valid", n_valid - nv, 0);
    check_val("disabled_no_overrun", 32'(overrun), 0);
    check_val("sample_hold", sample, 198);

    // second edge at E+4 -> overrun, one sample only
    nv = n_valid;
    ch_data = {16'sd200, 16'sd200, 16'sd200};
    ch_vol  = 12'hFFF;
    ch_ack  = 3'b111;
    sb_q.push_back('{597, 12});
    clk_48kHz = 1'b1;
    t0 = cyc;
    repeat (2) @(negedge clk_27MHz);
    clk_48kHz = 1'b0;
    repeat (2) @(negedge clk_27MHz);
    clk_48kHz = 1'b1;
    wait_done(100);
    clk_48kHz = 1'b0;
    repeat (20) @(negedge clk_27MHz);
    check_val("overrun_set", 32'(overrun), 1);
    check_val("overrun_one_valid", n_valid - nv, 1);
    err_clr = 1'b1;
    @(negedge clk_27MHz);
    err_clr = 1'b0;
    check_val("overrun_clr", 32'(overrun), 0);

    // reset in the middle of a frame while ch0 is being requested
    nv = n_valid;
    ch_ack = 3'b000;
    clk_48kHz = 1'b1;
    repeat (5) @(negedge clk_27MHz);
    check_val("midframe_req", 32'(ch_req), 1);
    reset_n = 1'b0;
    #1;
    check_val("async_req_drop", 32'(ch_req), 0);
    check_val("async_sample", sample, 0);
    check_val("async_valid", 32'(sample_valid), 0);
    clk_48kHz = 1'b0;
    repeat (2) @(negedge clk_27MHz);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_27MHz);
    check_val("reset_no_partial", n_valid - nv, 0);
    check_val("reset_idle_req", 32'(ch_req), 0);

    // normal operation after reset
    run_frame(1000, -1000, 0, 15, 15, 15, 3'b111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
